// File: rtl/alu_toggle_monitor.sv
// rtl/alu_toggle_monitor.sv - windowed Hamming-distance switching monitor for registered ALU outputs
// Flags windows whose accumulated toggle count falls outside a programmable golden band.
module alu_toggle_monitor #(
  parameter int WIN_LEN = 64,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] thr_lo,
  input  logic [CNT_W-1:0] thr_hi,
  input  logic             sample_valid,
  input  logic [3:0]       result,
  input  logic             carry,
  input  logic             zero,
  input  logic             overflow,
  output logic             busy,
  output logic             done,
  output logic             anomaly,
  output logic             saturated,
  output logic [CNT_W-1:0] toggle_total,
  output logic [2:0]       peak_toggles
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRIME  = 2'd1;
  localparam logic [1:0] ST_ACCUM  = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  localparam int               SC_W    = $clog2(WIN_LEN + 1);
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [6:0]       prev;
  logic [6:0]       obs;
  logic [6:0]       diff;
  logic [2:0]       hd;
  logic [SC_W-1:0]  sample_cnt;
  logic [CNT_W-1:0] thr_lo_q;
  logic [CNT_W-1:0] thr_hi_q;
  logic [CNT_W:0]   sum;

  assign obs  = {overflow, zero, carry, result};
  assign diff = obs ^ prev;
  assign busy = (state != ST_IDLE);

  always_comb begin
    hd = 3'd0;
    for (int i = 0; i < 7; i++) begin
      hd = hd + {2'b00, diff[i]};
    end
  end

  // One extra bit so an overflowing add is visible before clipping.
  assign sum = {1'b0, toggle_total} + (CNT_W + 1)'(hd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      prev         <= '0;
      sample_cnt   <= '0;
      thr_lo_q     <= '0;
      thr_hi_q     <= '0;
      done         <= 1'b0;
      anomaly      <= 1'b0;
      saturated    <= 1'b0;
      toggle_total <= '0;
      peak_toggles <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            thr_lo_q     <= thr_lo;
            thr_hi_q     <= thr_hi;
            toggle_total <= '0;
            peak_toggles <= '0;
            saturated    <= 1'b0;
            anomaly      <= 1'b0;
            sample_cnt   <= '0;
            state        <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          if (sample_valid) begin
            prev  <= obs;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (sample_valid) begin
            if (sum > {1'b0, CNT_MAX}) begin
              toggle_total <= CNT_MAX;
              saturated    <= 1'b1;
            end else begin
              toggle_total <= sum[CNT_W-1:0];
            end
            if (hd > peak_toggles) begin
              peak_toggles <= hd;
            end
            prev       <= obs;
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == SC_LAST) begin
              state <= ST_REPORT;
            end
          end
        end
        default: begin
          anomaly <= (toggle_total < thr_lo_q) | (toggle_total > thr_hi_q) | saturated;
          done    <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_toggle_monitor.sv
// tb/tb_alu_toggle_monitor.sv - scoreboard bench for alu_toggle_monitor (WIN_LEN=4, CNT_W=10 and CNT_W=4)
module tb_alu_toggle_monitor;

  localparam int WIN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] thr_lo = '0;
  logic [9:0] thr_hi = '0;
  logic       sample_valid = 1'b0;
  logic [6:0] obs_drv = '0;

  logic       busy, done, anomaly, saturated;
  logic [9:0] toggle_total;
  logic [2:0] peak_toggles;
  logic       s_busy, s_done, s_anomaly, s_saturated;
  logic [3:0] s_toggle_total;
  logic [2:0] s_peak_toggles;

  alu_toggle_monitor #(.WIN_LEN(WIN), .CNT_W(10)) u_dut (
    .clk(clk), .rst(rst), .start(start), .thr_lo(thr_lo), .thr_hi(thr_hi),
    .sample_valid(sample_valid), .result(obs_drv[3:0]), .carry(obs_drv[4]),
    .zero(obs_drv[5]), .overflow(obs_drv[6]),
    .busy(busy), .done(done), .anomaly(anomaly), .saturated(saturated),
    .toggle_total(toggle_total), .peak_toggles(peak_toggles)
  );

  alu_toggle_monitor #(.WIN_LEN(WIN), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .thr_lo(thr_lo[3:0]), .thr_hi(thr_hi[3:0]),
    .sample_valid(sample_valid), .result(obs_drv[3:0]), .carry(obs_drv[4]),
    .zero(obs_drv[5]), .overflow(obs_drv[6]),
    .busy(s_busy), .done(s_done), .anomaly(s_anomaly), .saturated(s_saturated),
    .toggle_total(s_toggle_total), .peak_toggles(s_peak_toggles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     total10;
    bit     sat10;
    bit     an10;
    int     total4;
    bit     sat4;
    bit     an4;
    int     peak;
    longint done_cyc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       last_exp;
  bit         have_last = 0;
  logic [6:0] win[$];
  longint     cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  int         n_done = 0;
  int         n_push = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: total switching is the sum of popcounts of successive XORs, clipped to the counter range.
  function automatic exp_t model(input logic [9:0] lo, input logic [9:0] hi);
    exp_t e;
    int   raw = 0;
    int   pk = 0;
    int   h;
    for (int i = 1; i < win.size(); i++) begin
      h = $countones(win[i] ^ win[i-1]);
      raw += h;
      if (h > pk) pk = h;
    end
    e.peak    = pk;
    e.sat10   = raw > 1023;
    e.total10 = e.sat10 ? 1023 : raw;
    e.an10    = (e.total10 < int'(lo)) || (e.total10 > int'(hi)) || e.sat10;
    e.sat4    = raw > 15;
    e.total4  = e.sat4 ? 15 : raw;
    e.an4     = (e.total4 < int'(lo[3:0])) || (e.total4 > int'(hi[3:0])) || e.sat4;
    e.done_cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (done || s_done)) begin
      n_done++;
      chk("done_pair", s_done, done);
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("total10", toggle_total, e.total10);
        chk("sat10", saturated, e.sat10);
        chk("anomaly10", anomaly, e.an10);
        chk("peak10", peak_toggles, e.peak);
        chk("total4", s_toggle_total, e.total4);
        chk("sat4", s_saturated, e.sat4);
        chk("anomaly4", s_anomaly, e.an4);
        chk("peak4", s_peak_toggles, e.peak);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plays win[] as one window; returns in the cycle where done should be high.
  task automatic run_window(input logic [9:0] lo, input logic [9:0] hi, input int max_gap, input bit mid_start);
    exp_t e;
    if (have_last) begin
      chk("hold_total", toggle_total, last_exp.total10);
      chk("hold_anomaly", anomaly, last_exp.an10);
      chk("hold_peak", peak_toggles, last_exp.peak);
    end
    thr_lo = lo;
    thr_hi = hi;
    start  = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < win.size(); i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        obs_drv = 7'($urandom);
        if (mid_start && i == 2) begin
          start  = 1'b1;
          thr_lo = 10'd0;
          thr_hi = 10'd1023;
        end
        step();
        start  = 1'b0;
        thr_lo = lo;
        thr_hi = hi;
      end
      obs_drv      = win[i];
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      obs_drv      = 7'($urandom);
    end
    e = model(lo, hi);
    e.done_cyc = cyc + 1;
    sb_q.push_back(e);
    n_push++;
    last_exp  = e;
    have_last = 1;
    step();
  endtask

  task automatic idle_noise(input int n);
    repeat (n) begin
      sample_valid = 1'($urandom);
      obs_drv      = 7'($urandom);
      step();
    end
    sample_valid = 1'b0;
  endtask

  task automatic load_result_seq(input logic [3:0] a, input logic [3:0] b);
    win.delete();
    for (int i = 0; i <= WIN; i++) win.push_back({3'b000, (i % 2 == 0) ? a : b});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_anomaly", anomaly, 0);
    chk("rst_sat", saturated, 0);
    chk("rst_total", toggle_total, 0);
    chk("rst_peak", peak_toggles, 0);
    rst = 1'b0;
    idle_noise(3);

    // Quiet window
    win.delete();
    for (int i = 0; i <= WIN; i++) win.push_back(7'h00);
    run_window(10'd0, 10'd8, 0, 0);
    chk("s1_total", toggle_total, 0);
    chk("s1_anomaly", anomaly, 0);
    idle_noise(4);

    // Excess toggling
    load_result_seq(4'h0, 4'hF);
    run_window(10'd0, 10'd8, 0, 0);
    chk("s2_total", toggle_total, 16);
    chk("s2_peak", peak_toggles, 4);
    chk("s2_anomaly", anomaly, 1);
    idle_noise(4);

    // Saturation on the narrow instance
    win.delete();
    for (int i = 0; i <= WIN; i++) win.push_back((i % 2 == 0) ? 7'h00 : 7'h7F);
    run_window(10'd0, 10'd8, 0, 0);
    chk("s3_total4", s_toggle_total, 15);
    chk("s3_sat4", s_saturated, 1);
    chk("s3_peak4", s_peak_toggles, 7);
    chk("s3_total10", toggle_total, 28);
    idle_noise(4);

    // Gaps plus ignored start during accumulation
    load_result_seq(4'h0, 4'hF);
    run_window(10'd0, 10'd8, 3, 1);
    chk("s4_total", toggle_total, 16);
    chk("s4_anomaly", anomaly, 1);
    idle_noise(5);

    // Reset mid-window
    thr_lo = 10'd0;
    thr_hi = 10'd8;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      obs_drv      = (i % 2 == 0) ? 7'h00 : 7'h0F;
      sample_valid = 1'b1;
      step();
    end
    sample_valid = 1'b0;
    chk("s5_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("s5_busy", busy, 0);
    chk("s5_total", toggle_total, 0);
    chk("s5_peak", peak_toggles, 0);
    chk("s5_anomaly", anomaly, 0);
    chk("s5_sat4", s_saturated, 0);
    have_last = 0;
    step();
    rst = 1'b0;
    idle_noise(8);
    win.delete();
    for (int i = 0; i <= WIN; i++) win.push_back(7'h00);
    run_window(10'd0, 10'd8, 1, 0);
    chk("s5_after_total", toggle_total, 0);

    // Back-to-back: next start lands in the done cycle
    load_result_seq(4'h1, 4'h3);
    run_window(10'd2, 10'd6, 0, 0);
    chk("s6_total", toggle_total, 4);
    chk("s6_anomaly", anomaly, 0);
    chk("s6_done_now", done, 1);

    // Randomized windows, some back-to-back
    for (int w = 0; w < 12; w++) begin
      win.delete();
      for (int i = 0; i <= WIN; i++) win.push_back(7'($urandom));
      run_window(10'($urandom_range(20, 0)), 10'($urandom_range(28, 4)), 2, w % 3 == 0);
      if ($urandom_range(1, 0) == 1) idle_noise($urandom_range(4, 1));
    end

    idle_noise(10);
    chk("queue_drained", sb_q.size(), 0);
    chk("done_count", n_done, n_push);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
